// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
interface if_fetch_stage_if;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;

    modport master (output IMEM_REQ, IMEM_ADDR, input  IMEM_RVALID, IMEM_RDATA);
    modport slave  (input  IMEM_REQ, IMEM_ADDR, output IMEM_RVALID, IMEM_RDATA);
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, keeps one fetch outstanding, and feeds IF/ID with a valid-qualified
// instruction slot. Branch/jump redirects flush the slot and discard any in-flight fetch.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   STALL,
    input  logic                   BRANCH_TAKEN,
    input  logic [31:0]            BRANCH_TARGET,
    input  logic                   JUMP,
    input  logic [31:0]            JUMP_TARGET,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            NEXT_INS_ADR,
    output logic [31:0]            CUR_INS,
    output logic                   INS_VALID
);
    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] nxt_q, nxt_d;
    logic        vld_q, vld_d;

    logic        redirect, slot_free, req, load;
    logic [31:0] target, pc_plus4;

    assign redirect  = BRANCH_TAKEN | JUMP;
    assign target    = (BRANCH_TAKEN ? BRANCH_TARGET : JUMP_TARGET) & 32'hFFFF_FFFC;
    assign slot_free = !vld_q || !STALL;
    assign req       = (state_q == S_ISSUE) && slot_free && !redirect;
    assign pc_plus4  = pc_q + 32'd4;
    assign load      = (state_q == S_WAIT) && imem.IMEM_RVALID && !redirect;

    assign imem.IMEM_REQ  = req;
    assign imem.IMEM_ADDR = pc_q;
    assign CUR_INS        = cur_q;
    assign NEXT_INS_ADR   = nxt_q;
    assign INS_VALID      = vld_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_ISSUE;
            pc_q    <= RESET_PC;
            cur_q   <= '0;
            nxt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        vld_d   = vld_q;

        if (vld_q && !STALL)
            vld_d = 1'b0;

        case (state_q)
            S_ISSUE: if (req) state_d = S_WAIT;
            S_WAIT: begin
                // A response coinciding with a redirect is wrong-path: drop it but the fetch is done.
                if (imem.IMEM_RVALID)
                    state_d = S_ISSUE;
                else if (redirect)
                    state_d = S_DISCARD;
            end
            S_DISCARD: if (imem.IMEM_RVALID) state_d = S_ISSUE;
            default: state_d = S_ISSUE;
        endcase

        if (load) begin
            cur_d = imem.IMEM_RDATA;
            nxt_d = pc_plus4;
            vld_d = 1'b1;
            pc_d  = pc_plus4;
        end

        // Flush wins over a held (stalled) instruction.
        if (redirect) begin
            pc_d  = target;
            vld_d = 1'b0;
        end
    end

    a_no_resp_into_full_slot: assert property (@(posedge CLK) disable iff (!RST_N)
        !(imem.IMEM_RVALID && vld_q && STALL));
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: fetch latency, stall hold, redirects, wrap-around, async reset.
module tb_if_fetch_stage;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        stall, br, jmp;
    logic [31:0] brt, jmpt;
    logic [31:0] next_adr, cur_ins;
    logic        ins_valid;

    logic        stall2, rv2;
    logic [31:0] rd2;
    logic [31:0] next_adr2, cur_ins2;
    logic        ins_valid2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    if_fetch_stage_if bus ();
    if_fetch_stage_if bus2 ();

    assign bus2.IMEM_RVALID = rv2;
    assign bus2.IMEM_RDATA  = rd2;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST_N(RST_N), .STALL(stall),
        .BRANCH_TAKEN(br), .BRANCH_TARGET(brt), .JUMP(jmp), .JUMP_TARGET(jmpt),
        .imem(bus), .NEXT_INS_ADR(next_adr), .CUR_INS(cur_ins), .INS_VALID(ins_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .STALL(stall2),
        .BRANCH_TAKEN(1'b0), .BRANCH_TARGET(32'h0), .JUMP(1'b0), .JUMP_TARGET(32'h0),
        .imem(bus2), .NEXT_INS_ADR(next_adr2), .CUR_INS(cur_ins2), .INS_VALID(ins_valid2)
    );

    // Instruction memory for dut: latches a request mid-cycle, answers lat cycles later.
    int          lat  = 1;
    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : {16'hC0DE, a[15:0]};
    endfunction

    always @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend = 1'b0;
            bus.IMEM_RVALID = 1'b0;
            bus.IMEM_RDATA  = 32'h0;
        end else begin
            bus.IMEM_RVALID = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.IMEM_RVALID = 1'b1;
                    bus.IMEM_RDATA  = mem(paddr);
                    pend = 1'b0;
                end
            end else if (bus.IMEM_REQ) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = bus.IMEM_ADDR;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST_N = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0; brt = '0; jmpt = '0;
        stall2 = 1'b0; rv2 = 1'b0; rd2 = '0;
        nxt(); nxt();
        #1;
        chk("rst_valid", {31'b0, ins_valid}, 32'd0);
        chk("rst_cur", cur_ins, 32'h0);
        chk("rst_next", next_adr, 32'h0);
        chk("rst_addr", bus.IMEM_ADDR, 32'h0);
        chk("rst_addr2", bus2.IMEM_ADDR, 32'hFFFF_FFFC);

        // cycle 0: first request
        RST_N = 1'b1; #1;
        chk("c0_req", {31'b0, bus.IMEM_REQ}, 32'd1);
        chk("c0_addr", bus.IMEM_ADDR, 32'h0);
        chk("c0_req2", {31'b0, bus2.IMEM_REQ}, 32'd1);
        chk("c0_addr2", bus2.IMEM_ADDR, 32'hFFFF_FFFC);

        // cycle 1: dut waiting; dut2 gets its response
        nxt(); rv2 = 1'b1; rd2 = 32'h1234_5678; #1;
        chk("c1_valid", {31'b0, ins_valid}, 32'd0);
        chk("c1_req", {31'b0, bus.IMEM_REQ}, 32'd0);

        // cycle 2: instruction presented; stall it
        nxt(); rv2 = 1'b0; stall = 1'b1; #1;
        chk("c2_valid", {31'b0, ins_valid}, 32'd1);
        chk("c2_cur", cur_ins, 32'h2008_0005);
        chk("c2_next", next_adr, 32'h4);
        chk("c2_addr", bus.IMEM_ADDR, 32'h4);
        chk("c2_req_stalled", {31'b0, bus.IMEM_REQ}, 32'd0);
        chk("wrap_valid", {31'b0, ins_valid2}, 32'd1);
        chk("wrap_cur", cur_ins2, 32'h1234_5678);
        chk("wrap_next", next_adr2, 32'h0);
        chk("wrap_addr", bus2.IMEM_ADDR, 32'h0);
        chk("wrap_req", {31'b0, bus2.IMEM_REQ}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            chk("stall_req", {31'b0, bus.IMEM_REQ}, 32'd0);
            chk("stall_valid", {31'b0, ins_valid}, 32'd1);
            chk("stall_cur", cur_ins, 32'h2008_0005);
            chk("stall_next", next_adr, 32'h4);
        end

        // release: request issues in the same cycle
        nxt(); stall = 1'b0; #1;
        chk("rel_req", {31'b0, bus.IMEM_REQ}, 32'd1);
        chk("rel_addr", bus.IMEM_ADDR, 32'h4);
        nxt(); lat = 2; #1;
        chk("rel_consumed", {31'b0, ins_valid}, 32'd0);
        nxt(); #1;
        chk("f4_valid", {31'b0, ins_valid}, 32'd1);
        chk("f4_cur", cur_ins, 32'hC0DE_0004);
        chk("f4_next", next_adr, 32'h8);
        chk("f8_req", {31'b0, bus.IMEM_REQ}, 32'd1);

        // jump while waiting, one cycle before the response
        nxt(); jmp = 1'b1; jmpt = 32'h0000_0100; #1;
        chk("jw_req", {31'b0, bus.IMEM_REQ}, 32'd0);
        nxt(); jmp = 1'b0; #1;
        chk("disc_valid", {31'b0, ins_valid}, 32'd0);
        chk("disc_req", {31'b0, bus.IMEM_REQ}, 32'd0);
        chk("disc_addr", bus.IMEM_ADDR, 32'h100);
        nxt(); #1;
        chk("stale_dropped", {31'b0, ins_valid}, 32'd0);
        chk("post_disc_req", {31'b0, bus.IMEM_REQ}, 32'd1);
        chk("post_disc_addr", bus.IMEM_ADDR, 32'h100);
        nxt(); nxt();
        nxt(); stall = 1'b1; #1;
        chk("f100_valid", {31'b0, ins_valid}, 32'd1);
        chk("f100_cur", cur_ins, 32'hC0DE_0100);
        chk("f100_next", next_adr, 32'h104);

        // simultaneous branch and jump over a stalled instruction
        nxt(); br = 1'b1; brt = 32'h40; jmp = 1'b1; jmpt = 32'h80; #1;
        chk("bj_req", {31'b0, bus.IMEM_REQ}, 32'd0);
        nxt(); br = 1'b0; jmp = 1'b0; #1;
        chk("bj_flush", {31'b0, ins_valid}, 32'd0);
        chk("bj_pc", bus.IMEM_ADDR, 32'h40);
        chk("bj_req_after", {31'b0, bus.IMEM_REQ}, 32'd1);
        // redirect in ISSUE suppresses the request; target low bits cleared
        jmp = 1'b1; jmpt = 32'h203; #1;
        chk("ji_req", {31'b0, bus.IMEM_REQ}, 32'd0);
        nxt(); jmp = 1'b0; #1;
        chk("ji_addr", bus.IMEM_ADDR, 32'h200);
        chk("ji_req_after", {31'b0, bus.IMEM_REQ}, 32'd1);

        // async reset mid-WAIT, restore a visible instruction first
        nxt(); #1;
        chk("pre_rst_cur", cur_ins, 32'hC0DE_0100);
        RST_N = 1'b0; #1;
        chk("arst_valid", {31'b0, ins_valid}, 32'd0);
        chk("arst_cur", cur_ins, 32'h0);
        chk("arst_next", next_adr, 32'h0);
        chk("arst_addr", bus.IMEM_ADDR, 32'h0);
        nxt(); RST_N = 1'b1; stall = 1'b0; lat = 1; #1;
        chk("arst_req", {31'b0, bus.IMEM_REQ}, 32'd1);
        chk("arst_addr2", bus.IMEM_ADDR, 32'h0);
        nxt(); nxt(); #1;
        chk("refetch_valid", {31'b0, ins_valid}, 32'd1);
        chk("refetch_cur", cur_ins, 32'h2008_0005);
        chk("refetch_next", next_adr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the PC and issues one-outstanding requests to instruction memory. Presents each fetched instruction and its PC+4 to IF/ID with a valid flag. Honours the hazard-unit stall and redirects from branch/jump resolution, discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST_N  in  1  asynchronous, active-low reset.
STALL  in  1  downstream not ready; the output slot is held when 1.
BRANCH_TAKEN  in  1  redirect to BRANCH_TARGET this cycle.
BRANCH_TARGET  in  32  branch destination.
JUMP  in  1  redirect to JUMP_TARGET this cycle.
JUMP_TARGET  in  32  jump destination.
IMEM_REQ  out  1  fetch request; combinational, one-cycle pulse.
IMEM_ADDR  out  32  fetch address; equals PC.
IMEM_RVALID  in  1  response valid; at least 1 cycle after request.
IMEM_RDATA  in  32  instruction word, valid with IMEM_RVALID.
NEXT_INS_ADR  out  32  PC+4 of the presented instruction (to IF/ID NEXT_INS_ADR_IN).
CUR_INS  out  32  presented instruction (to IF/ID CUR_INS_IN).
INS_VALID  out  1  CUR_INS/NEXT_INS_ADR valid; consumed on any cycle with INS_VALID=1 and STALL=0.

Behaviour:
- Reset (RST_N=0, asynchronous): PC=RESET_PC, state=ISSUE, CUR_INS=0, NEXT_INS_ADR=0, INS_VALID=0.
- Reset mid-fetch: the in-flight request is abandoned. Instruction memory shares RST_N, so no stale response arrives.
- redirect = BRANCH_TAKEN | JUMP.
- Target selection: BRANCH_TAKEN has priority over JUMP. Target bits [1:0] are forced to 0.
- slot_free = !INS_VALID | !STALL.
- IMEM_REQ = (state==ISSUE) & slot_free & !redirect.
- IMEM_ADDR = PC at all times.
- States:
  - ISSUE: if IMEM_REQ, go to WAIT. Otherwise stay in ISSUE.
  - WAIT: on IMEM_RVALID & !redirect: CUR_INS<=IMEM_RDATA, NEXT_INS_ADR<=PC+4, INS_VALID<=1, PC<=PC+4, go to ISSUE. Otherwise stay in WAIT.
  - DISCARD: on IMEM_RVALID, drop the data and go to ISSUE. Otherwise stay in DISCARD.
- Redirect (any state):
  - PC<=target and INS_VALID<=0 (flush dominates STALL).
  - From WAIT without RVALID: go to DISCARD.
  - From WAIT with RVALID in the same cycle: drop the data, go to ISSUE.
  - From ISSUE: no request is issued, stay in ISSUE.
  - From DISCARD: stay in DISCARD.
- Consumption: if INS_VALID & !STALL and no new response loads this cycle, INS_VALID<=0.
  - Output registers otherwise hold their values.
  - While INS_VALID=1 and STALL=1, CUR_INS and NEXT_INS_ADR are stable.
- Latency: request in cycle N, RVALID in N+1, INS_VALID=1 from N+2. Back-to-back peak is 1 instruction per 2 cycles.
- Stall behaviour: a fetch already in WAIT completes only into a free slot.
  - The slot is guaranteed free because ISSUE issues only when slot_free.
  - A response arriving when INS_VALID=1 & STALL=1 is impossible by construction; the assertion checks it.
- Arithmetic: PC+4 is modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000). PC[1:0] is always 0.
- Only one request is outstanding at any time.

Test Plan:
- Reset/first fetch: RESET_PC=0, memory responds 1 cycle later with 32'h2008_0005 -> IMEM_REQ at cycle 0 with ADDR 0; INS_VALID=1 at cycle 2 with CUR_INS=32'h2008_0005, NEXT_INS_ADR=4; next request is to ADDR 4.
- Stall hold: hold STALL=1 for 5 cycles with INS_VALID=1 -> no IMEM_REQ, outputs stable. Release STALL -> request to the next PC is issued the same cycle.
- Redirect in WAIT: jump to 32'h0000_0100 the cycle before RVALID -> stale response dropped, INS_VALID stays 0, next IMEM_ADDR=32'h100.
- Simultaneous BRANCH_TAKEN (target 32'h40) and JUMP (target 32'h80) with a held stalled instruction -> INS_VALID cleared despite STALL, PC=32'h40.
- Wrap-around: RESET_PC=32'hFFFF_FFFC -> NEXT_INS_ADR=0, next fetch ADDR 0.
- Asynchronous reset asserted mid-WAIT between clock edges -> outputs zero immediately, PC=RESET_PC, state ISSUE after release.
